// File: rtl/see_tmr_reg.sv
// see_tmr_reg
//   Triple-redundant storage register. Three replicas of a W-bit value are
//   held side by side; each replica takes its own upset mask from the SEE
//   insertion stage every cycle. The bitwise majority vote is presented on
//   s_q_o. Disagreement among the replicas is reported per replica and in
//   aggregate. A saturating counter records the number of cycles in which
//   any disagreement was present.
//
//   Compile-time option:
//     SEE_SCRUB_EN - when defined, every replica reloads the voted value on
//                    non-write cycles (continuous correction). When undefined,
//                    each replica holds its own value, so errors accumulate.
//
//   Parameters:
//     W       width of the stored value
//     RST_VAL reset value loaded into all replicas
//     CNT_W   width of the disagreement counter
//
//   Ports:
//     s_clk_i     clock, rising edge
//     s_resetn_i  asynchronous active-low reset
//     s_we_i      write enable
//     s_d_i       write data
//     s_upset_i   per-replica flip masks (entry i flips replica i)
//     s_clr_i     synchronous clear of the disagreement counter
//     s_q_o       bitwise majority of the three replicas
//     s_err_o     some replica differs from s_q_o
//     s_erep_o    bit i set when replica i differs from s_q_o
//     s_cnt_o     saturating count of cycles with s_err_o high
module see_tmr_reg #(
   parameter int unsigned    W       = 32,
   parameter logic [W-1:0]   RST_VAL = '0,
   parameter int unsigned    CNT_W   = 8
) (
   input  logic             s_clk_i,
   input  logic             s_resetn_i,
   input  logic             s_we_i,
   input  logic [W-1:0]     s_d_i,
   input  logic [W-1:0]     s_upset_i [3],
   input  logic             s_clr_i,
   output logic [W-1:0]     s_q_o,
   output logic             s_err_o,
   output logic [2:0]       s_erep_o,
   output logic [CNT_W-1:0] s_cnt_o
);

   logic [W-1:0]     r_rep   [3];
   logic [W-1:0]     rep_nxt [3];
   logic [CNT_W-1:0] r_cnt;

   // Majority vote and disagreement flags, purely combinational.
   always_comb begin
      s_q_o = (r_rep[0] & r_rep[1]) | (r_rep[0] & r_rep[2]) | (r_rep[1] & r_rep[2]);
      s_erep_o = '0;
      for (int unsigned i = 0; i < 3; i++) begin
         s_erep_o[i[1:0]] = |(r_rep[i[1:0]] ^ s_q_o);
      end
      s_err_o = |s_erep_o;
   end

   // Upset is applied after base selection so a write in the same cycle
   // still ends up corrupted.
   always_comb begin
      for (int unsigned i = 0; i < 3; i++) begin
         rep_nxt[i[1:0]] = '0;
         if (s_we_i) begin
            rep_nxt[i[1:0]] = s_d_i;
         end else begin
`ifdef SEE_SCRUB_EN
            rep_nxt[i[1:0]] = s_q_o;
`else
            rep_nxt[i[1:0]] = r_rep[i[1:0]];
`endif
         end
         rep_nxt[i[1:0]] = rep_nxt[i[1:0]] ^ s_upset_i[i[1:0]];
      end
   end

   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         for (int unsigned i = 0; i < 3; i++) begin
            r_rep[i[1:0]] <= RST_VAL;
         end
      end else begin
         for (int unsigned i = 0; i < 3; i++) begin
            r_rep[i[1:0]] <= rep_nxt[i[1:0]];
         end
      end
   end

   always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
      if (!s_resetn_i) begin
         r_cnt <= '0;
      end else if (s_clr_i) begin
         r_cnt <= '0;
      end else if (s_err_o && (r_cnt != '1)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign s_cnt_o = r_cnt;

endmodule
